// File: rtl/demux_1x5_pkg.sv
// Shared constants and state encoding for the 1-to-5 lane demultiplexer.
package demux_1x5_pkg;

    localparam int unsigned LANE_W = 3;
    localparam int unsigned LANES  = 5;
    localparam int unsigned SEL_W  = 3;
    localparam int unsigned CNT_W  = 8;
    localparam int          MIN_VAL = -2;
    localparam int          MAX_VAL = 2;

    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } state_t;

endpackage

// File: rtl/lane_check.sv
// Decodes a beat's lane select into a one-hot write enable and flags illegal
// select or out-of-range data; a bad select masks the range error.
module lane_check
    import demux_1x5_pkg::*;
#(
    parameter int unsigned W = LANE_W,
    parameter int unsigned N = LANES
) (
    input  logic [SEL_W-1:0] sel,
    input  logic [W-1:0]     data,
    output logic [N-1:0]     we_c,
    output logic             err_sel_c,
    output logic             err_range_c
);

    int value;

    always_comb begin
        we_c        = '0;
        value       = int'($signed(data));
        err_sel_c   = (32'(sel) >= N);
        err_range_c = !err_sel_c && ((value < MIN_VAL) || (value > MAX_VAL));
        if (!err_sel_c && !err_range_c) begin
            for (int k = 0; k < int'(N); k++) begin
                if (int'(sel) == k) we_c[k] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/demux_1x5.sv
// Assembles five signed lane beats into one frame, holds it until the consumer
// takes it, and reports dropped or overwriting beats as one-cycle pulses.
module demux_1x5 #(
    parameter int unsigned LANE_W = demux_1x5_pkg::LANE_W,
    parameter int unsigned LANES  = demux_1x5_pkg::LANES
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [LANE_W-1:0]                   in_data,
    input  logic [demux_1x5_pkg::SEL_W-1:0]     in_sel,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic                                flush,
    output logic [LANES*LANE_W-1:0]             out_data,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [LANES-1:0]                    lane_valid,
    output logic                                err_sel,
    output logic                                err_range,
    output logic                                err_dup,
    output logic [demux_1x5_pkg::CNT_W-1:0]     frame_cnt
);

    import demux_1x5_pkg::*;

    state_t                  state_q, state_d;
    logic [LANES*LANE_W-1:0] data_q, data_d;
    logic [LANES-1:0]        lv_q, lv_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    in_ready_q, in_ready_d;
    logic                    out_valid_q, out_valid_d;
    logic                    err_sel_q, err_sel_d;
    logic                    err_range_q, err_range_d;
    logic                    err_dup_q, err_dup_d;

    logic [LANES-1:0]        we_c;
    logic                    sel_bad_c;
    logic                    range_bad_c;

    lane_check #(
        .W (LANE_W),
        .N (LANES)
    ) u_lane_check (
        .sel         (in_sel),
        .data        (in_data),
        .we_c        (we_c),
        .err_sel_c   (sel_bad_c),
        .err_range_c (range_bad_c)
    );

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= FILL;
            data_q      <= '0;
            lv_q        <= '0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            err_sel_q   <= 1'b0;
            err_range_q <= 1'b0;
            err_dup_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            data_q      <= data_d;
            lv_q        <= lv_d;
            cnt_q       <= cnt_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            err_sel_q   <= err_sel_d;
            err_range_q <= err_range_d;
            err_dup_q   <= err_dup_d;
        end
    end

    // Next-state: flush dominates any beat or release in the same cycle.
    always_comb begin
        state_d     = state_q;
        data_d      = data_q;
        lv_d        = lv_q;
        cnt_d       = cnt_q;
        err_sel_d   = 1'b0;
        err_range_d = 1'b0;
        err_dup_d   = 1'b0;

        if (flush) begin
            state_d = FILL;
            data_d  = '0;
            lv_d    = '0;
        end else begin
            case (state_q)
                FILL: begin
                    if (in_valid) begin
                        if (sel_bad_c) begin
                            err_sel_d = 1'b1;
                        end else if (range_bad_c) begin
                            err_range_d = 1'b1;
                        end else begin
                            for (int k = 0; k < int'(LANES); k++) begin
                                if (we_c[k]) data_d[k*LANE_W +: LANE_W] = in_data;
                            end
                            err_dup_d = |(lv_q & we_c);
                            lv_d      = lv_q | we_c;
                            if (&lv_d) state_d = FULL;
                        end
                    end
                end
                FULL: begin
                    if (out_ready) begin
                        state_d = FILL;
                        data_d  = '0;
                        lv_d    = '0;
                        cnt_d   = cnt_q + CNT_W'(1);
                    end
                end
                default: state_d = FILL;
            endcase
        end

        in_ready_d  = (state_d == FILL);
        out_valid_d = (state_d == FULL);
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign out_data   = data_q;
    assign lane_valid = lv_q;
    assign err_sel    = err_sel_q;
    assign err_range  = err_range_q;
    assign err_dup    = err_dup_q;
    assign frame_cnt  = cnt_q;

endmodule

// File: tb/tb_demux_1x5.sv
// Scenario bench for demux_1x5: a lane model predicts errors and frames, and
// completed frames are queued and matched against the released output.
module tb_demux_1x5;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  in_data;
    logic [2:0]  in_sel;
    logic        in_valid;
    logic        in_ready;
    logic        flush;
    logic [14:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  lane_valid;
    logic        err_sel;
    logic        err_range;
    logic        err_dup;
    logic [7:0]  frame_cnt;

    int checks   = 0;
    int failures = 0;

    logic [14:0] sb_q[$];
    logic [2:0]  m_lane[5];
    logic [4:0]  m_lv;
    logic [7:0]  m_cnt;
    logic        m_full;

    demux_1x5 dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_data    (in_data),
        .in_sel     (in_sel),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .flush      (flush),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .lane_valid (lane_valid),
        .err_sel    (err_sel),
        .err_range  (err_range),
        .err_dup    (err_dup),
        .frame_cnt  (frame_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [14:0] m_frame();
        logic [14:0] f;
        for (int k = 0; k < 5; k++) f[k*3 +: 3] = m_lane[k];
        return f;
    endfunction

    task automatic m_clear();
        for (int k = 0; k < 5; k++) m_lane[k] = 3'b000;
        m_lv   = 5'b0;
        m_full = 1'b0;
    endtask

    // Predicts {dup, range, sel} for a beat, then drives it for one cycle.
    task automatic beat(input logic [2:0] sel, input logic [2:0] data, output logic [2:0] e);
        e = 3'b000;
        if (!m_full) begin
            if (sel > 3'd4) e[0] = 1'b1;
            else if (data == 3'b011 || data == 3'b100) e[1] = 1'b1;
            else begin
                e[2]         = m_lv[sel];
                m_lane[sel]  = data;
                m_lv[sel]    = 1'b1;
                if (m_lv == 5'h1f) begin
                    m_full = 1'b1;
                    sb_q.push_back(m_frame());
                end
            end
        end
        in_valid = 1'b1;
        in_sel   = sel;
        in_data  = data;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Performs a one-cycle release handshake, returning the held and queued frames.
    task automatic do_release(output logic [14:0] seen, output logic [14:0] exp);
        seen = out_data;
        exp  = (sb_q.size() > 0) ? sb_q.pop_front() : 15'bx;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        m_clear();
        m_cnt = m_cnt + 8'd1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_sel = '0; in_data = '0;
        flush = 1'b0; out_ready = 1'b0;
        m_clear(); m_cnt = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (out_data !== 15'h0) begin failures++; $display("FAIL reset_out_data got=%h exp=0", out_data); end
        checks++; if (lane_valid !== 5'h0) begin failures++; $display("FAIL reset_lane_valid got=%b exp=0", lane_valid); end
        checks++; if ({in_ready, out_valid} !== 2'b10) begin failures++; $display("FAIL reset_handshake got=%b exp=10", {in_ready, out_valid}); end
        checks++; if ({err_dup, err_range, err_sel} !== 3'b000) begin failures++; $display("FAIL reset_errs got=%b exp=000", {err_dup, err_range, err_sel}); end
        checks++; if (frame_cnt !== 8'd0) begin failures++; $display("FAIL reset_frame_cnt got=%0d exp=0", frame_cnt); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_frame();
        logic [2:0] vals[5];
        logic [2:0] e;
        vals[0] = 3'b110; vals[1] = 3'b111; vals[2] = 3'b000; vals[3] = 3'b001; vals[4] = 3'b010;
        for (int k = 0; k < 5; k++) begin
            beat(3'(k), vals[k], e);
            checks++; if (lane_valid !== m_lv) begin failures++; $display("FAIL frame_lane_valid beat=%0d got=%b exp=%b", k, lane_valid, m_lv); end
        end
        checks++; if (out_data !== 15'h223E) begin failures++; $display("FAIL frame_out_data got=%h exp=223e", out_data); end
        checks++; if ({out_valid, in_ready} !== 2'b10) begin failures++; $display("FAIL frame_full got=%b exp=10", {out_valid, in_ready}); end
        beat(3'd0, 3'b001, e);
        checks++; if (out_data !== 15'h223E) begin failures++; $display("FAIL full_ignores_beat got=%h exp=223e", out_data); end
    endtask

    task automatic test_hold_release();
        logic [14:0] seen, exp;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk);
            #1;
            checks++; if ({out_valid, out_data} !== {1'b1, 15'h223E}) begin failures++; $display("FAIL hold_stable cycle=%0d got=%b/%h exp=1/223e", c, out_valid, out_data); end
        end
        do_release(seen, exp);
        checks++; if (seen !== exp) begin failures++; $display("FAIL release_frame got=%h exp=%h", seen, exp); end
        checks++; if ({out_valid, in_ready, lane_valid} !== 7'b0100000) begin failures++; $display("FAIL release_state got=%b exp=0100000", {out_valid, in_ready, lane_valid}); end
        checks++; if (frame_cnt !== 8'd1) begin failures++; $display("FAIL release_frame_cnt got=%0d exp=1", frame_cnt); end
    endtask

    task automatic test_errors();
        logic [2:0] e;
        beat(3'd6, 3'b001, e);
        checks++; if ({err_dup, err_range, err_sel} !== 3'b001 || e !== 3'b001) begin failures++; $display("FAIL err_sel_pulse got=%b exp=001", {err_dup, err_range, err_sel}); end
        beat(3'd2, 3'b100, e);
        checks++; if ({err_dup, err_range, err_sel} !== 3'b010 || e !== 3'b010) begin failures++; $display("FAIL err_range_pulse got=%b exp=010", {err_dup, err_range, err_sel}); end
        beat(3'd6, 3'b011, e);
        checks++; if ({err_dup, err_range, err_sel} !== 3'b001 || e !== 3'b001) begin failures++; $display("FAIL err_sel_priority got=%b exp=001", {err_dup, err_range, err_sel}); end
        @(posedge clk);
        #1;
        checks++; if ({err_dup, err_range, err_sel, lane_valid} !== 8'h00) begin failures++; $display("FAIL err_clear got=%b exp=00000000", {err_dup, err_range, err_sel, lane_valid}); end
    endtask

    task automatic test_dup();
        logic [2:0] e;
        beat(3'd1, 3'b001, e);
        checks++; if (err_dup !== 1'b0) begin failures++; $display("FAIL dup_first got=%b exp=0", err_dup); end
        beat(3'd1, 3'b111, e);
        checks++; if ({err_dup, out_data[5:3]} !== {e[2], 3'b111}) begin failures++; $display("FAIL dup_overwrite got=%b exp=1111", {err_dup, out_data[5:3]}); end
        @(posedge clk);
        #1;
        checks++; if ({err_dup, lane_valid} !== {1'b0, m_lv}) begin failures++; $display("FAIL dup_one_cycle got=%b exp=0%b", {err_dup, lane_valid}, m_lv); end
    endtask

    task automatic test_flush();
        logic [2:0] e;
        beat(3'd0, 3'b010, e);
        beat(3'd2, 3'b110, e);
        checks++; if (lane_valid !== 5'b00111) begin failures++; $display("FAIL flush_pre_lanes got=%b exp=00111", lane_valid); end
        flush = 1'b1; in_valid = 1'b1; in_sel = 3'd3; in_data = 3'b001;
        @(posedge clk);
        #1;
        flush = 1'b0; in_valid = 1'b0;
        m_clear();
        checks++; if ({lane_valid, out_data} !== 20'h0) begin failures++; $display("FAIL flush_clear got=%b/%h exp=0/0", lane_valid, out_data); end
        checks++; if ({in_ready, out_valid, err_dup, err_range, err_sel} !== 5'b10000) begin failures++; $display("FAIL flush_state got=%b exp=10000", {in_ready, out_valid, err_dup, err_range, err_sel}); end
        checks++; if (frame_cnt !== m_cnt) begin failures++; $display("FAIL flush_frame_cnt got=%0d exp=%0d", frame_cnt, m_cnt); end
    endtask

    task automatic test_wrap_and_reset();
        logic [2:0]  e;
        logic [14:0] seen, exp;
        for (int f = 0; f < 255; f++) begin
            for (int i = 0; i < 5; i++) beat(3'((i + f) % 5), 3'(int'($urandom_range(0, 4)) - 2), e);
            do_release(seen, exp);
            checks++; if (seen !== exp) begin failures++; $display("FAIL wrap_frame f=%0d got=%h exp=%h", f, seen, exp); end
        end
        checks++; if (frame_cnt !== 8'd0 || m_cnt !== 8'd0) begin failures++; $display("FAIL frame_cnt_wrap got=%0d exp=0", frame_cnt); end
        for (int i = 0; i < 5; i++) beat(3'(4 - i), 3'b001, e);
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL pre_reset_full got=%b exp=1", out_valid); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if ({out_data, lane_valid, out_valid, in_ready} !== {15'h0, 5'h0, 2'b01}) begin failures++; $display("FAIL async_reset got=%h/%b/%b%b exp=0/0/01", out_data, lane_valid, out_valid, in_ready); end
        checks++; if ({err_dup, err_range, err_sel, frame_cnt} !== 11'h0) begin failures++; $display("FAIL async_reset_cnt got=%b/%0d exp=000/0", {err_dup, err_range, err_sel}, frame_cnt); end
        sb_q.delete();
        m_clear();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++; if ({frame_cnt, out_valid, in_ready} !== {8'd0, 2'b01}) begin failures++; $display("FAIL post_reset got=%0d/%b%b exp=0/01", frame_cnt, out_valid, in_ready); end
        checks++; if (sb_q.size() != 0) begin failures++; $display("FAIL scoreboard_leftover got=%0d exp=0", sb_q.size()); end
    endtask

    initial begin
        test_reset();
        test_frame();
        test_hold_release();
        test_errors();
        test_dup();
        test_flush();
        test_wrap_and_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/demux_1x5.md
DEMUX_1X5 -- requirements
Module: demux_1x5

Interface
REQ-001 Parameter: LANE_W, default 3; bits per lane, holding a two's-complement value.
REQ-002 Parameter: LANES, default 5; number of output lanes; the only supported value is 5.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset; asynchronous assert, active-low.
REQ-005 in_data  input  3  signed lane value; legal range -2..2.
REQ-006 in_sel  input  3  destination lane, 0..4.
REQ-007 in_valid  input  1  in_data/in_sel are offered this cycle.
REQ-008 in_ready  output  1  block accepts a beat this cycle.
REQ-009 flush  input  1  synchronous discard of the partial or held frame.
REQ-010 out_data  output  15  assembled frame; lane k occupies bits [3k+2:3k].
REQ-011 out_valid  output  1  a complete frame is held on out_data.
REQ-012 out_ready  input  1  consumer takes the frame.
REQ-013 lane_valid  output  5  bit k set means lane k has been written in the current frame.
REQ-014 err_sel  output  1  one-cycle pulse: a beat was dropped because in_sel was 5..7.
REQ-015 err_range  output  1  one-cycle pulse: a beat was dropped because in_data was 3'b011 or 3'b100.
REQ-016 err_dup  output  1  one-cycle pulse: an accepted beat overwrote an already-valid lane.
REQ-017 frame_cnt  output  8  count of released frames; wraps from 255 to 0.

Function
REQ-018 The block SHALL have two states: FILL and FULL.
REQ-019 The block SHALL drive in_ready=1 in FILL and in_ready=0 in FULL; a beat is accepted only when in_valid and in_ready are both 1.
REQ-020 An accepted beat SHALL be dropped, with err_sel pulsed in the next cycle, when in_sel is 5..7.
REQ-021 Otherwise, an accepted beat SHALL be dropped, with err_range pulsed in the next cycle, when in_data is 3 or -4.
- in_sel error takes priority: one pulse only, on err_sel.
REQ-022 A legal beat SHALL write in_data into lane in_sel and set lane_valid[in_sel], both visible in the next cycle.
- If that lane was already valid: the new value overwrites it and err_dup pulses.
REQ-023 When a legal beat makes lane_valid all ones, the block SHALL enter FULL at the same edge, so out_valid=1 in the cycle after the fifth beat.
REQ-024 In FULL, out_data and lane_valid SHALL stay stable until out_valid and out_ready are both 1.
REQ-025 On that release handshake, at the next edge:
- all lanes clear to 0;
- lane_valid clears to 0;
- frame_cnt increments;
- the state returns to FILL, so out_valid=0 and in_ready=1.
REQ-026 out_ready SHALL be ignored while in FILL.
REQ-027 flush=1 SHALL, at the next edge:
- clear all lanes and lane_valid;
- force FILL;
- discard any concurrent beat or release.
frame_cnt is unchanged and no error pulses are raised.
REQ-028 out_valid SHALL be a registered output; it is never combinationally dependent on out_ready.
REQ-029 Error pulses SHALL be exactly one cycle long per offending beat, so back-to-back bad beats give consecutive pulses.

Reset
REQ-030 While rst_n=0, the block SHALL hold:
- state FILL, in_ready=1;
- out_data=0, lane_valid=0, out_valid=0;
- err_sel, err_range, err_dup = 0;
- frame_cnt=0.
REQ-031 Reset asserted mid-frame or in FULL SHALL discard the frame without incrementing frame_cnt.
REQ-032 The first accept SHALL be possible on the first rising edge after rst_n deasserts.

Structure
REQ-033 Package demux_1x5_pkg SHALL hold:
- LANE_W=3, LANES=5, MIN_VAL=-2, MAX_VAL=2;
- the state enum {FILL, FULL}.
REQ-034 One combinational sub-module, lane_check, SHALL decode in_sel into a 5-bit one-hot write enable and flag the sel and range errors; all registers live in demux_1x5.

Verification
REQ-035 After reset, beats sel 0..4 carrying -2,-1,0,1,2 -> out_data=15'h223E, out_valid=1 in the cycle after the 5th beat, in_ready=0.
REQ-036 Frame held with out_ready=0 for 4 cycles, then 1 -> out_data stable throughout; after release out_valid=0, lane_valid=0, frame_cnt=1.
REQ-037 Beats (sel=6, data=1), (sel=2, data=3'b100), (sel=6, data=3'b011) -> err_sel, err_range, err_sel pulses on consecutive cycles; lane_valid stays 0.
REQ-038 sel=1 written with 1, then with -1 -> err_dup=1 for one cycle; lane 1 reads 3'b111.
REQ-039 Three lanes filled, then flush=1 coincident with a valid beat -> lane_valid=0, out_data=0, state FILL, frame_cnt unchanged.
REQ-040 Release 256 frames -> frame_cnt wraps to 0; rst_n pulsed low while in FULL -> all outputs return to their reset values immediately.
